grain_keystream_scheduler: RTL and testbench
============================================

# grain_keystream_scheduler

Shares one Grain keystream generator (80-bit seed, DATA_WIDTH-bit output words) between NUM_REQ bus-side requesters. The block owns the generator's seed-load and enable controls and accepts seed updates. It arbitrates burst requests round-robin and routes each generated word to the requester that owns the current burst. It sits between the peripheral bus front-ends and the single generator instance.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, keystream word width
- SEED_WIDTH, 80, generator seed width

Ports:
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- req_i  in  NUM_REQ  burst request per requester, level
- len_i  in  4*NUM_REQ  burst length minus 1 per requester (0 → 1 word, 15 → 16 words), sampled at grant
- gnt_o  out  NUM_REQ  one-hot, one-cycle grant pulse
- rvalid_o  out  NUM_REQ  one-hot, one-cycle word-valid to burst owner
- rdata_o  out  DATA_WIDTH  keystream word, meaningful only with rvalid_o
- done_o  out  NUM_REQ  one-cycle pulse coincident with last rvalid of a burst
- seed_valid_i  in  1  new seed offered
- seed_i  in  SEED_WIDTH  seed value
- seed_ready_o  out  1  seed accepted when seed_valid_i && seed_ready_o
- lfsr_seed_o  out  SEED_WIDTH  registered seed to generator
- lfsr_seed_load_o  out  1  one-cycle seed-load pulse
- lfsr_enable_o  out  1  generator enable
- lfsr_ready_i  in  1  generator word-ready strobe
- lfsr_data_i  in  DATA_WIDTH  generator word

## Operation
- States: UNSEEDED, LOAD, IDLE, RUN.
- Reset: state UNSEEDED, RR pointer 0, word counter 0, owner 0; all outputs 0 except seed_ready_o = 1.
- seed_ready_o = 1 in UNSEEDED and IDLE, 0 in LOAD and RUN (state decode).
- UNSEEDED: requests ignored, no grants. Seed handshake → capture seed_i into lfsr_seed_o, go LOAD.
- LOAD: lfsr_seed_load_o = 1 for exactly this cycle, then IDLE.
- IDLE: a seed handshake has priority over requests (→ LOAD, no grant this cycle). Otherwise, if any req_i is set, grant the first set bit at or after the RR pointer (wrapping). Latch owner and len_i[owner] into counter, pointer ← (owner+1) mod NUM_REQ, go RUN.
- RUN: lfsr_enable_o = 1. Each cycle lfsr_ready_i = 1 → register lfsr_data_i to rdata_o and pulse rvalid_o[owner]. If counter = 0, also pulse done_o[owner], drop lfsr_enable_o, and go IDLE; else decrement counter.
- req_i is sampled only at grant. Deassertion mid-burst has no effect; the burst always completes.
- A requester holding req_i after done_o is re-arbitrated normally. The rotated pointer guarantees others are served first.
- lfsr_ready_i outside RUN is ignored: no rvalid_o, data dropped.
- rdata_o holds its last value between words. It is not cleared.
- Reset asserted mid-burst: immediate return to reset values. No done_o for the aborted burst. Seed lost → UNSEEDED.

## Timing
- Grant: request seen in IDLE cycle T → gnt_o and lfsr_enable_o high in T+1 (first RUN cycle).
- Word: lfsr_ready_i high in cycle R → rvalid_o/rdata_o in R+1.
- Last word: done_o in R+1, lfsr_enable_o low from R+1, state IDLE in R+1. Earliest next gnt_o is R+2.
- Seed: handshake in cycle S → lfsr_seed_o valid and lfsr_seed_load_o high in S+1. Back in IDLE at S+2, where seed_ready_o = 1 again.
- Back-to-back lfsr_ready_i every cycle yields rvalid_o every cycle. A burst of len+1 words needs exactly len+1 ready strobes.

## Test plan
- Reset, req_i = 4'b0001 held, no seed for 20 cycles → gnt_o stays 0, seed_ready_o = 1. Seed 80'h1234 accepted at S → lfsr_seed_load_o pulses at S+1, lfsr_seed_o = 80'h1234.
- Seeded; req_i[2] = 1 with len 3; ready strobed every cycle with data 1,2,3,4 → gnt_o = 4'b0100 one cycle; rvalid_o[2] ×4 with rdata_o 1..4; done_o[2] on word 4; enable low the next cycle.
- All four requesters held high, len 0 each → grants in order 0,1,2,3,0. Each grant follows the previous done_o by exactly 1 cycle.
- In IDLE, seed_valid_i and req_i[1] both high in the same cycle → seed loaded, no grant. Grant to 1 is issued after returning to IDLE.
- Mid-burst (len 7, 3 words delivered): drop req_i → remaining 5 words are still delivered. seed_valid_i during RUN sees seed_ready_o = 0 until IDLE.
- rst_i pulsed in RUN → next cycle all outputs 0, seed_ready_o = 1. A subsequent req is ignored until a reseed.

Source files
------------

// File: rtl/grain_keystream_scheduler.sv
// grain_keystream_scheduler
// Shares a single Grain keystream generator between NUM_REQ requesters.
// Owns the generator seed-load/enable controls, accepts seed updates,
// arbitrates bursts round-robin and steers each generated word to the
// requester owning the current burst.
module grain_keystream_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SEED_WIDTH = 80
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [4*NUM_REQ-1:0]    len_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [NUM_REQ-1:0]      done_o,
  input  logic                    seed_valid_i,
  input  logic [SEED_WIDTH-1:0]   seed_i,
  output logic                    seed_ready_o,
  output logic [SEED_WIDTH-1:0]   lfsr_seed_o,
  output logic                    lfsr_seed_load_o,
  output logic                    lfsr_enable_o,
  input  logic                    lfsr_ready_i,
  input  logic [DATA_WIDTH-1:0]   lfsr_data_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_LOAD     = 2'd1,
    ST_IDLE     = 2'd2,
    ST_RUN      = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [PW-1:0]           owner_q, owner_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [SEED_WIDTH-1:0]   seed_q, seed_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0]      done_q, done_d;

  logic                    seed_ready_s;
  logic                    seed_hs_s;
  logic                    found_s;
  logic [PW-1:0]           pick_s;
  int                      cand_s;

  // Seed is only accepted while no burst is pending or being served.
  assign seed_ready_s = (state_q == ST_UNSEEDED) || (state_q == ST_IDLE);
  assign seed_hs_s    = seed_valid_i && seed_ready_s;

  // Round-robin search: first set request at or after the pointer, wrapping.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = (int'(ptr_q) + i) % NUM_REQ;
      if (!found_s && req_i[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s[PW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // State register and all datapath flops; synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_UNSEEDED;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= 4'd0;
      seed_q   <= '0;
      rdata_q  <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      seed_q   <= seed_d;
      rdata_q  <= rdata_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; seed handshake wins over a pending request in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNSEEDED: begin
        if (seed_hs_s) state_d = ST_LOAD;
        else           state_d = ST_UNSEEDED;
      end
      ST_LOAD: state_d = ST_IDLE;
      ST_IDLE: begin
        if (seed_hs_s)    state_d = ST_LOAD;
        else if (found_s) state_d = ST_RUN;
        else              state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (lfsr_ready_i && (cnt_q == 4'd0)) state_d = ST_IDLE;
        else                                 state_d = ST_RUN;
      end
      default: state_d = ST_UNSEEDED;
    endcase
  end

  // Next values for seed, grant, burst bookkeeping and word routing.
  always_comb begin
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    seed_d   = seed_q;
    rdata_d  = rdata_q;
    gnt_d    = '0;
    rvalid_d = '0;
    done_d   = '0;
    case (state_q)
      ST_UNSEEDED: begin
        if (seed_hs_s) seed_d = seed_i;
        else           seed_d = seed_q;
      end
      ST_IDLE: begin
        if (seed_hs_s) begin
          seed_d = seed_i;
        end else if (found_s) begin
          owner_d        = pick_s;
          cnt_d          = len_i[{pick_s, 2'b00} +: 4];
          gnt_d[pick_s]  = 1'b1;
          if (pick_s == PW'(NUM_REQ - 1)) ptr_d = '0;
          else                            ptr_d = pick_s + PW'(1);
        end else begin
          ptr_d = ptr_q;
        end
      end
      ST_RUN: begin
        if (lfsr_ready_i) begin
          rdata_d           = lfsr_data_i;
          rvalid_d[owner_q] = 1'b1;
          if (cnt_q == 4'd0) done_d[owner_q] = 1'b1;
          else               cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = rdata_q;
        end
      end
      default: begin
        seed_d = seed_q;
      end
    endcase
  end

  assign gnt_o            = gnt_q;
  assign rvalid_o         = rvalid_q;
  assign done_o           = done_q;
  assign rdata_o          = rdata_q;
  assign lfsr_seed_o      = seed_q;
  assign seed_ready_o     = seed_ready_s;
  assign lfsr_seed_load_o = (state_q == ST_LOAD);
  assign lfsr_enable_o    = (state_q == ST_RUN);

endmodule

// File: tb/tb_grain_keystream_scheduler.sv
// Directed bench for grain_keystream_scheduler (NUM_REQ=4, 32-bit words).
// Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_grain_keystream_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  req_i = 4'd0;
  logic [15:0] len_i = 16'd0;
  logic [3:0]  gnt_o, rvalid_o, done_o;
  logic [31:0] rdata_o;
  logic        seed_valid_i = 1'b0;
  logic [79:0] seed_i = 80'd0;
  logic        seed_ready_o;
  logic [79:0] lfsr_seed_o;
  logic        lfsr_seed_load_o, lfsr_enable_o;
  logic        lfsr_ready_i = 1'b0;
  logic [31:0] lfsr_data_i = 32'd0;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  grain_keystream_scheduler #(.NUM_REQ(4), .DATA_WIDTH(32), .SEED_WIDTH(80)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .len_i(len_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .done_o(done_o),
    .seed_valid_i(seed_valid_i), .seed_i(seed_i), .seed_ready_o(seed_ready_o),
    .lfsr_seed_o(lfsr_seed_o), .lfsr_seed_load_o(lfsr_seed_load_o),
    .lfsr_enable_o(lfsr_enable_o), .lfsr_ready_i(lfsr_ready_i),
    .lfsr_data_i(lfsr_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    logic gnt_seen;
    rst_i = 1'b1;
    tick(); tick();
    chk_cnt++; if ({gnt_o, rvalid_o, done_o, lfsr_seed_load_o, lfsr_enable_o} !== 14'd0)
      $display("FAIL reset_ctrl: got %h expected 0", {gnt_o, rvalid_o, done_o, lfsr_seed_load_o, lfsr_enable_o}); else pass_cnt++;
    chk_cnt++; if ({rdata_o, lfsr_seed_o} !== 112'd0)
      $display("FAIL reset_data: got %h expected 0", {rdata_o, lfsr_seed_o}); else pass_cnt++;
    chk_cnt++; if (seed_ready_o !== 1'b1)
      $display("FAIL reset_seed_ready: got %b expected 1", seed_ready_o); else pass_cnt++;
    rst_i = 1'b0;
    req_i = 4'b0001;
    gnt_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt_o !== 4'd0 || lfsr_enable_o !== 1'b0 || seed_ready_o !== 1'b1) gnt_seen = 1'b1;
    end
    chk_cnt++; if (gnt_seen !== 1'b0)
      $display("FAIL unseeded_no_grant: got %b expected 0", gnt_seen); else pass_cnt++;
    seed_valid_i = 1'b1; seed_i = 80'h1234; req_i = 4'd0;
    tick();
    seed_valid_i = 1'b0;
    chk_cnt++; if ({lfsr_seed_load_o, seed_ready_o} !== 2'b10)
      $display("FAIL seed_load_pulse: got %b expected 10", {lfsr_seed_load_o, seed_ready_o}); else pass_cnt++;
    chk_cnt++; if (lfsr_seed_o !== 80'h1234)
      $display("FAIL seed_value: got %h expected 1234", lfsr_seed_o); else pass_cnt++;
    tick();
    chk_cnt++; if ({lfsr_seed_load_o, seed_ready_o, gnt_o} !== 6'b010000)
      $display("FAIL seed_back_idle: got %b expected 010000", {lfsr_seed_load_o, seed_ready_o, gnt_o}); else pass_cnt++;
  endtask

  task automatic test_burst;
    req_i = 4'b0100; len_i = 16'h0300;
    tick();
    chk_cnt++; if ({gnt_o, lfsr_enable_o} !== 5'b01001)
      $display("FAIL burst_grant: got %b expected 01001", {gnt_o, lfsr_enable_o}); else pass_cnt++;
    req_i = 4'd0; len_i = 16'd0; lfsr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lfsr_data_i = 32'(i + 1);
      tick();
      chk_cnt++; if ({rvalid_o, gnt_o, done_o} !== {4'b0100, 4'b0000, (i == 3) ? 4'b0100 : 4'b0000})
        $display("FAIL burst_word%0d_ctrl: got %b", i, {rvalid_o, gnt_o, done_o}); else pass_cnt++;
      chk_cnt++; if (rdata_o !== 32'(i + 1))
        $display("FAIL burst_word%0d_data: got %h expected %h", i, rdata_o, i + 1); else pass_cnt++;
      chk_cnt++; if (lfsr_enable_o !== ((i == 3) ? 1'b0 : 1'b1))
        $display("FAIL burst_word%0d_enable: got %b", i, lfsr_enable_o); else pass_cnt++;
    end
    lfsr_ready_i = 1'b0;
    tick();
    chk_cnt++; if ({rvalid_o, done_o} !== 8'd0 || rdata_o !== 32'd4)
      $display("FAIL burst_hold: got %b %h expected 0 00000004", {rvalid_o, done_o}, rdata_o); else pass_cnt++;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; seed_valid_i = 1'b1; seed_i = 80'h5;
    tick();
    seed_valid_i = 1'b0; req_i = 4'b1111; len_i = 16'd0; lfsr_ready_i = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      lfsr_data_i = 32'hA0 + 32'(k);
      tick();
      chk_cnt++; if ({gnt_o, rvalid_o} !== {exp, 4'b0000})
        $display("FAIL rr_grant%0d: got %b expected %b", k, {gnt_o, rvalid_o}, {exp, 4'b0000}); else pass_cnt++;
      tick();
      chk_cnt++; if ({gnt_o, rvalid_o, done_o} !== {4'b0000, exp, exp} || rdata_o !== 32'hA0 + 32'(k))
        $display("FAIL rr_done%0d: got %b %h", k, {gnt_o, rvalid_o, done_o}, rdata_o); else pass_cnt++;
    end
    req_i = 4'd0; lfsr_ready_i = 1'b0;
  endtask

  task automatic test_seed_priority;
    seed_valid_i = 1'b1; seed_i = 80'hBEEF; req_i = 4'b0010;
    tick();
    seed_valid_i = 1'b0;
    chk_cnt++; if ({gnt_o, lfsr_seed_load_o, seed_ready_o} !== 6'b000010 || lfsr_seed_o !== 80'hBEEF)
      $display("FAIL prio_seed: got %b %h", {gnt_o, lfsr_seed_load_o, seed_ready_o}, lfsr_seed_o); else pass_cnt++;
    tick();
    chk_cnt++; if ({gnt_o, seed_ready_o} !== 5'b00001)
      $display("FAIL prio_idle: got %b expected 00001", {gnt_o, seed_ready_o}); else pass_cnt++;
    tick();
    chk_cnt++; if (gnt_o !== 4'b0010)
      $display("FAIL prio_grant: got %b expected 0010", gnt_o); else pass_cnt++;
    req_i = 4'd0; lfsr_ready_i = 1'b1; lfsr_data_i = 32'h77;
    tick();
    lfsr_ready_i = 1'b0;
    chk_cnt++; if ({rvalid_o, done_o} !== 8'b00100010 || rdata_o !== 32'h77)
      $display("FAIL prio_word: got %b %h", {rvalid_o, done_o}, rdata_o); else pass_cnt++;
  endtask

  task automatic test_midburst;
    req_i = 4'b0100; len_i = 16'h0700;
    tick();
    chk_cnt++; if (gnt_o !== 4'b0100)
      $display("FAIL mid_grant: got %b expected 0100", gnt_o); else pass_cnt++;
    lfsr_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lfsr_data_i = 32'h10 + 32'(i);
      tick();
      chk_cnt++; if (rvalid_o !== 4'b0100 || rdata_o !== 32'h10 + 32'(i))
        $display("FAIL mid_word%0d: got %b %h", i, rvalid_o, rdata_o); else pass_cnt++;
    end
    req_i = 4'd0; seed_valid_i = 1'b1; seed_i = 80'hCAFE; lfsr_ready_i = 1'b0;
    tick();
    chk_cnt++; if ({rvalid_o, seed_ready_o, lfsr_seed_load_o} !== 6'd0 || rdata_o !== 32'h12)
      $display("FAIL mid_gap: got %b %h", {rvalid_o, seed_ready_o, lfsr_seed_load_o}, rdata_o); else pass_cnt++;
    lfsr_ready_i = 1'b1;
    for (int i = 3; i < 8; i++) begin
      lfsr_data_i = 32'h10 + 32'(i);
      tick();
      chk_cnt++; if ({rvalid_o, done_o} !== {4'b0100, (i == 7) ? 4'b0100 : 4'b0000} || rdata_o !== 32'h10 + 32'(i))
        $display("FAIL mid_word%0d: got %b %h", i, {rvalid_o, done_o}, rdata_o); else pass_cnt++;
      chk_cnt++; if ({seed_ready_o, lfsr_seed_load_o} !== {(i == 7), 1'b0})
        $display("FAIL mid_seed_ready%0d: got %b", i, {seed_ready_o, lfsr_seed_load_o}); else pass_cnt++;
    end
    lfsr_ready_i = 1'b0;
    tick();
    seed_valid_i = 1'b0;
    chk_cnt++; if (lfsr_seed_load_o !== 1'b1 || lfsr_seed_o !== 80'hCAFE || gnt_o !== 4'd0)
      $display("FAIL mid_reseed: got %b %h", lfsr_seed_load_o, lfsr_seed_o); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_midburst;
    logic gnt_seen;
    req_i = 4'b1000; len_i = 16'h5000;
    tick();
    chk_cnt++; if (gnt_o !== 4'b1000)
      $display("FAIL rstmid_grant: got %b expected 1000", gnt_o); else pass_cnt++;
    req_i = 4'd0; lfsr_ready_i = 1'b1; lfsr_data_i = 32'h1;
    tick();
    lfsr_data_i = 32'h2;
    tick();
    rst_i = 1'b1;
    tick();
    chk_cnt++; if ({gnt_o, rvalid_o, done_o, lfsr_seed_load_o, lfsr_enable_o, seed_ready_o} !== 15'b1 || {rdata_o, lfsr_seed_o} !== 112'd0)
      $display("FAIL rstmid_outputs: got %b %h", {gnt_o, rvalid_o, done_o, lfsr_seed_load_o, lfsr_enable_o, seed_ready_o}, rdata_o); else pass_cnt++;
    rst_i = 1'b0; lfsr_ready_i = 1'b0; req_i = 4'b1111; len_i = 16'd0;
    gnt_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gnt_o !== 4'd0) gnt_seen = 1'b1;
    end
    chk_cnt++; if (gnt_seen !== 1'b0)
      $display("FAIL rstmid_ignored: got %b expected 0", gnt_seen); else pass_cnt++;
    seed_valid_i = 1'b1; seed_i = 80'h99;
    tick();
    seed_valid_i = 1'b0;
    chk_cnt++; if (lfsr_seed_load_o !== 1'b1)
      $display("FAIL rstmid_reseed: got %b expected 1", lfsr_seed_load_o); else pass_cnt++;
    tick(); tick();
    chk_cnt++; if (gnt_o !== 4'b0001)
      $display("FAIL rstmid_regrant: got %b expected 0001", gnt_o); else pass_cnt++;
    req_i = 4'd0;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_round_robin();
    test_seed_priority();
    test_midburst();
    test_reset_midburst();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
